muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Multi-cycle HI/LO arithmetic unit in the EX stage. It consumes the two operands the register file delivers on its rs/rt read ports (read_val1/read_val2). It executes MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO and owns the HI and LO architectural registers. It raises busy so the pipeline controller stalls MFHI/MFLO and further HI/LO ops until the result is committed.

Parameters:
DIV_ITER, 32, number of radix-2 restoring-division iterations; fixed to the operand width, not to be overridden.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request: op/operands valid this cycle
op  input  4  0000 NOP, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MTHI, 0110 MTLO, 0111 MADD, 1000 MADDU, 1001 MSUB, 1010 MSUBU, others reserved
operand_a  input  32  rs value from register file read port 1
operand_b  input  32  rt value from register file read port 2
flush  input  1  abort in-flight op (exception/branch squash)
busy  output  1  op in flight; start is ignored while high
done  output  1  one-cycle pulse in the cycle after HI/LO commit
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, busy=0, done=0, FSM=IDLE, all internal datapath registers cleared. Reset mid-operation discards the op and leaves no pending commit.
- FSM states: IDLE, MUL, DIV, FIX.
- Accept rule: start=1, busy=0, flush=0 at a rising edge -> op and operands are latched. Start while busy=1 is ignored with no side effect. NOP and reserved codes are accepted as no-ops: no state change, no done.
- MTHI/MTLO: hi (or lo) <= operand_a at the accepting edge. busy stays 0. done=1 for the following cycle.
- MULT/MULTU: IDLE->MUL at the accept edge, busy=1. At the next edge, {hi,lo} <= 64-bit product (signed or unsigned per op), FSM->IDLE, busy=0, done=1 for one cycle. Latency: 2 edges.
- DIV/DIVU: IDLE->DIV. Signed ops divide magnitudes. 32 iterations in DIV, one per cycle, driven by an iteration counter 0..31. Then FIX (one cycle) applies sign correction and commits. Total: accept edge + 32 + 1 edges. busy is high from the accept edge until the commit edge.
- Division semantics: quotient -> lo, remainder -> hi. Quotient truncates toward zero. Remainder takes the sign of the dividend.
- Divide by zero: detected at accept. FSM goes straight to FIX (commit 2 edges after accept) with lo=32'hFFFFFFFF, hi=operand_a.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. No trap.
- flush=1 at any edge: in-flight op discarded, FSM->IDLE, busy=0 after that edge, hi/lo unchanged, no done. flush has priority over both commit and accept in the same cycle.
- Simultaneous commit edge and new start: start is ignored because busy=1 in that cycle. The new op is accepted one cycle later.
- hi/lo change only at commit edges (or MTHI/MTLO); the outputs are registered directly.

Optional Feature:
MULDIV_MADD_EN defined:
- MADD/MADDU: {hi,lo} <= {hi,lo} + product.
- MSUB/MSUBU: {hi,lo} <= {hi,lo} - product.
- 64-bit wrap, same 2-edge MUL timing. Accumulation uses the hi/lo values present at the commit edge.

MULDIV_MADD_EN undefined:
- Codes 0111-1010 are treated as reserved no-ops: accepted, no busy, no done, hi/lo unchanged.
- No accumulate adder is synthesised.

Test Plan:
- Reset: assert rst_n=0 mid-DIV -> hi=lo=0, busy=0 immediately; after release, a fresh MULT completes normally.
- MULT: a=0xFFFFFFFE (-2), b=3 -> after 2 edges hi=0xFFFFFFFF, lo=0xFFFFFFFA, one done pulse. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV: a=-7 (0xFFFFFFF9), b=2 -> busy for 33 cycles after accept, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- Boundaries: DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, commit 2 edges after accept.
- Handshake: start MULT while DIV busy -> ignored, DIV result intact. Flush at iteration 10 of DIV -> busy drops, hi/lo keep their prior values (MTHI 0x1234 earlier -> hi=0x1234), no done pulse.
- MADD with the macro defined: {hi,lo}=0x00000000_FFFFFFFF, MADDU 1*1 -> hi=1, lo=0. Same stimulus without the macro -> hi/lo unchanged, no busy.

Source files
------------

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU/MTHI/MTLO, plus MADD/MSUB family when MULDIV_MADD_EN is defined.
// Latency: MTHI/MTLO commit at accept edge; MUL 2 edges; DIV 34 edges (divide-by-zero 2); done pulses the cycle after commit.
// Backpressure: busy high while an op is in flight, start ignored then; flush aborts with no commit and no done.
module muldiv_unit #(
  parameter int DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MULDIV_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif
  localparam int          CW        = $clog2(DIV_ITER);
  localparam logic [CW-1:0] LAST_ITER = CW'(DIV_ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [3:0]    r_op;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [31:0]   r_rem;
  logic [31:0]   r_quo;
  logic [CW-1:0] r_cnt;
  logic          r_neg_q;
  logic          r_neg_r;
  logic          r_div0;

  // Multiply: sign-extend to 64 bits so the low 64 product bits are right for both signednesses.
  logic        w_mul_signed;
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_prod;
  logic [63:0] w_mul_res;

`ifdef MULDIV_MADD_EN
  assign w_mul_signed = (r_op == OP_MULT) || (r_op == OP_MADD) || (r_op == OP_MSUB);
`else
  assign w_mul_signed = (r_op == OP_MULT);
`endif
  assign w_mul_a = {{32{w_mul_signed & r_a[31]}}, r_a};
  assign w_mul_b = {{32{w_mul_signed & r_b[31]}}, r_b};
  assign w_prod  = w_mul_a * w_mul_b;

`ifdef MULDIV_MADD_EN
  always_comb begin
    w_mul_res = w_prod;
    if (r_op == OP_MADD || r_op == OP_MADDU)
      w_mul_res = {r_hi, r_lo} + w_prod;
    else if (r_op == OP_MSUB || r_op == OP_MSUBU)
      w_mul_res = {r_hi, r_lo} - w_prod;
  end
`else
  assign w_mul_res = w_prod;
`endif

  // Divide operand magnitudes, captured at accept.
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;

  assign w_a_neg = (op == OP_DIV) & operand_a[31];
  assign w_b_neg = (op == OP_DIV) & operand_b[31];
  assign w_mag_a = w_a_neg ? (~operand_a + 32'd1) : operand_a;
  assign w_mag_b = w_b_neg ? (~operand_b + 32'd1) : operand_b;

  // Restoring step: dividend bits shift out of r_quo while quotient bits shift in.
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = w_shift - {1'b0, r_b};
  assign w_ge    = ~w_diff[32];
  assign w_q_fix = r_neg_q ? (~r_quo + 32'd1) : r_quo;
  assign w_r_fix = r_neg_r ? (~r_rem + 32'd1) : r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              case (op)
                OP_MTHI: begin
                  r_hi   <= operand_a;
                  r_done <= 1'b1;
                end
                OP_MTLO: begin
                  r_lo   <= operand_a;
                  r_done <= 1'b1;
                end
`ifdef MULDIV_MADD_EN
                OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
`else
                OP_MULT, OP_MULTU: begin
`endif
                  r_op    <= op;
                  r_a     <= operand_a;
                  r_b     <= operand_b;
                  r_state <= S_MUL;
                  r_busy  <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                  r_op    <= op;
                  r_a     <= operand_a;
                  r_b     <= w_mag_b;
                  r_quo   <= w_mag_a;
                  r_rem   <= '0;
                  r_cnt   <= '0;
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
                  r_div0  <= (operand_b == 32'd0);
                  r_state <= (operand_b == 32'd0) ? S_FIX : S_DIV;
                  r_busy  <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          S_MUL: begin
            {r_hi, r_lo} <= w_mul_res;
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
          end
          S_DIV: begin
            r_rem <= w_ge ? w_diff[31:0] : w_shift[31:0];
            r_quo <= {r_quo[30:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_ITER)
              r_state <= S_FIX;
          end
          S_FIX: begin
            if (r_div0) begin
              r_hi <= r_a;
              r_lo <= 32'hFFFF_FFFF;
            end else begin
              r_hi <= w_r_fix;
              r_lo <= w_q_fix;
            end
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, handshake/flush/reset sequences, random ops vs a reference model.
module tb_muldiv_unit;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t tv [17];

  muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: architectural effect of one op on HI/LO, plus edges from accept to done sample.
  function automatic void ref_exec(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] h, inout logic [31:0] l, output int lat);
    longint      sp;
    logic [63:0] up;
    logic [63:0] acc;
    int          sa;
    int          sb;
    lat = 0;
    case (o)
      OP_MTHI: begin h = a; lat = 1; end
      OP_MTLO: begin l = a; lat = 1; end
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {h, l} = sp;
        lat = 2;
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {h, l} = up;
        lat = 2;
      end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          l = 32'hFFFF_FFFF;
          h = a;
          lat = 2;
        end else begin
          lat = 34;
          if (o == OP_DIVU) begin
            l = a / b;
            h = a % b;
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            l = 32'h8000_0000;
            h = 32'd0;
          end else begin
            sa = $signed(a);
            sb = $signed(b);
            l = sa / sb;
            h = sa % sb;
          end
        end
      end
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
        if (o == OP_MADD || o == OP_MSUB) begin
          sp = longint'($signed(a)) * longint'($signed(b));
          up = sp;
        end else begin
          up = {32'd0, a} * {32'd0, b};
        end
        acc = {h, l};
        acc = (o == OP_MADD || o == OP_MADDU) ? acc + up : acc - up;
        {h, l} = acc;
        lat = 2;
      end
`endif
      default: lat = 0;
    endcase
  endfunction

  // Issue one op from idle and check latency, busy duration, done pulse and final HI/LO.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int elat, input string nm);
    int   n;
    int   nb;
    logic sd;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    step();
    start = 1'b0; op = OP_NOP;
    n = 1; nb = 0; sd = 1'b0;
    if (elat == 0) begin
      for (int i = 0; i < 4; i++) begin
        if (done) sd = 1'b1;
        if (busy) nb++;
        step();
      end
      chk({nm, "_nodone"}, {31'd0, sd}, 32'd0);
      chk({nm, "_nobusy"}, 32'(nb), 32'd0);
    end else begin
      while (!done && n < 100) begin
        if (busy) nb++;
        step();
        n++;
      end
      chk({nm, "_latency"}, 32'(n), 32'(elat));
      chk({nm, "_busycyc"}, 32'(nb), 32'(elat - 1));
    end
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    if (elat != 0) begin
      step();
      chk({nm, "_pulse"}, {31'd0, done}, 32'd0);
    end
  endtask

  logic [3:0]  opl [12];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] ra;
  logic [31:0] rb;
  logic [3:0]  ro;
  int          rlat;
  int          n;
  logic        sd;

  initial begin
    tv[0]  = '{OP_MTHI,  32'h0000_1234, 32'h0,         32'h0000_1234, 32'h0000_0000, 1};
    tv[1]  = '{OP_MTLO,  32'h0000_5678, 32'h0,         32'h0000_1234, 32'h0000_5678, 1};
    tv[2]  = '{OP_MULT,  32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 2};
    tv[3]  = '{OP_MULTU, 32'hFFFF_FFFE, 32'h3,         32'h0000_0002, 32'hFFFF_FFFA, 2};
    tv[4]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    tv[5]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        34};
    tv[6]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 34};
    tv[7]  = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 2};
    tv[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34};
    tv[9]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 2};
    tv[10] = '{OP_NOP,   32'd0,         32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 0};
    tv[11] = '{4'hF,     32'd1,         32'd1,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 0};
    tv[12] = '{OP_MTHI,  32'd0,         32'd0,         32'h0,         32'hFFFF_FFFF, 1};
`ifdef MULDIV_MADD_EN
    tv[13] = '{OP_MADDU, 32'd1,         32'd1,         32'h1,         32'h0,         2};
    tv[14] = '{OP_MSUB,  32'd2,         32'd3,         32'h0,         32'hFFFF_FFFA, 2};
`else
    tv[13] = '{OP_MADDU, 32'd1,         32'd1,         32'h0,         32'hFFFF_FFFF, 0};
    tv[14] = '{OP_MSUB,  32'd2,         32'd3,         32'h0,         32'hFFFF_FFFF, 0};
`endif
    tv[15] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2};
    tv[16] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF, 34};

    opl = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO,
            OP_NOP, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, 4'hD};

    rst_n = 1'b0; start = 1'b0; op = OP_NOP; operand_a = '0; operand_b = '0; flush = 1'b0;
    #12;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 17; i++)
      run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].hi, tv[i].lo, tv[i].lat, $sformatf("vec%0d", i));

    // Start while a divide is in flight is ignored.
    start = 1'b1; op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd7;
    step();
    start = 1'b0;
    repeat (3) step();
    start = 1'b1; op = OP_MULT; operand_a = 32'd6; operand_b = 32'd7;
    step();
    start = 1'b0; op = OP_NOP;
    n = 5;
    while (!done && n < 100) begin step(); n++; end
    chk("busy_ignore_latency", 32'(n), 32'd34);
    chk("busy_ignore_hi", hi, 32'd2);
    chk("busy_ignore_lo", lo, 32'd14);
    sd = 1'b0;
    repeat (4) begin step(); if (done || busy) sd = 1'b1; end
    chk("busy_ignore_noextra", {31'd0, sd}, 32'd0);

    // Flush at iteration 10 discards the divide.
    run_op(OP_MTHI, 32'h1234, 32'd0, 32'h1234, 32'd14, 1, "pre_flush_mthi");
    run_op(OP_MTLO, 32'h77,   32'd0, 32'h1234, 32'h77, 1, "pre_flush_mtlo");
    start = 1'b1; op = OP_DIV; operand_a = 32'hFFFF_FFF9; operand_b = 32'd2;
    step();
    start = 1'b0;
    repeat (10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    sd = 1'b0;
    repeat (40) begin if (done || busy) sd = 1'b1; step(); end
    chk("flush_nodone", {31'd0, sd}, 32'd0);
    chk("flush_hi", hi, 32'h1234);
    chk("flush_lo", lo, 32'h77);

    // Flush beats a same-cycle accept.
    flush = 1'b1; start = 1'b1; op = OP_MTHI; operand_a = 32'hDEAD;
    step();
    flush = 1'b0; start = 1'b0; op = OP_NOP;
    chk("flush_start_done", {31'd0, done}, 32'd0);
    chk("flush_start_hi", hi, 32'h1234);

    // Start held across the commit edge is taken one cycle later.
    start = 1'b1; op = OP_MULT; operand_a = 32'd3; operand_b = 32'd5;
    step();
    op = OP_MTLO; operand_a = 32'hAAAA;
    step();
    chk("overlap_commit_done", {31'd0, done}, 32'd1);
    chk("overlap_commit_hi", hi, 32'd0);
    chk("overlap_commit_lo", lo, 32'd15);
    step();
    start = 1'b0; op = OP_NOP;
    chk("overlap_next_lo", lo, 32'hAAAA);
    chk("overlap_next_done", {31'd0, done}, 32'd1);
    step();

    // Asynchronous reset mid-divide, then a fresh multiply.
    start = 1'b1; op = OP_DIVU; operand_a = 32'd1000; operand_b = 32'd3;
    step();
    start = 1'b0; op = OP_NOP;
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    step();
    rst_n = 1'b1;
    sd = 1'b0;
    repeat (40) begin if (done) sd = 1'b1; step(); end
    chk("midrst_nocommit", {31'd0, sd}, 32'd0);
    run_op(OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 2, "post_rst_mult");

    m_hi = 32'd0;
    m_lo = 32'd42;
    for (int k = 0; k < 30; k++) begin
      ro = opl[$urandom_range(0, 11)];
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom;
      endcase
      ref_exec(ro, ra, rb, m_hi, m_lo, rlat);
      run_op(ro, ra, rb, m_hi, m_lo, rlat, $sformatf("rnd%0d_op%0d", k, ro));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
